pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised N-stage pipeline register chain with valid/ready handshake, global stall and per-stage flush.
//  Generalises the fixed IF/ID/EX latches of the processor pipeline into one reusable block.
//  Sits between pipeline stages (e.g. fetch->decode->execute).
//  The hazard unit drives stall; the branch resolve path drives flush.
// PARAMETERS
//  STAGES  4   number of register stages, >=1; stage 0 youngest, stage STAGES-1 drives output
//  DATA_W  32  payload width per stage
//  CNT_W   16  width of each performance counter
// PORTS
//  clk          in   1                 clock, all state updates on rising edge
//  rst          in   1                 synchronous reset, active-high
//  in_valid     in   1                 upstream payload valid
//  in_ready     out  1                 chain accepts in_data this cycle
//  in_data      in   DATA_W            upstream payload
//  out_valid    out  1                 vld_q[STAGES-1]
//  out_ready    in   1                 downstream accepts
//  out_data     out  DATA_W            data_q[STAGES-1]
//  stall        in   1                 hazard stall: freeze every stage
//  flush_mask   in   STAGES            bit i kills stage i at this edge
//  occupancy    out  $clog2(STAGES+1)  number of valid stages (registered)
//  perf_clr     in   1                 clear perf counters
//  perf_retired out  CNT_W             output handshakes
//  perf_stalled out  CNT_W             cycles with stall=1
//  perf_flushed out  CNT_W             valid entries killed by flush
// BEHAVIOUR
//  - Reset: vld_q all 0, data_q all 0, occupancy 0, perf counters 0.
//    in_ready = ~stall during reset cycle; inputs are ignored while rst=1.
//  - adv = ~stall & (out_ready | ~out_valid); in_ready = adv (combinational).
//  - Advance (adv=1): data_q[i] <= data_q[i-1], vld_q[i] <= vld_q[i-1]; stage 0 takes in_data/in_valid.
//  - Hold (adv=0): data_q and vld_q hold.
//  - Flush has priority over advance and hold: flush_mask[i]=1 -> vld_q[i] <= 0.
//    Mask indexes the destination stage after the shift.
//  - Flush + accept: in_valid & adv & flush_mask[0] -> input consumed (handshake done), stored invalid.
//  - Latency: accepted item appears on out_valid exactly STAGES advancing cycles after acceptance.
//    No bubble collapse: an invalid stage still occupies a slot.
//  - out_valid/out_data stable while out_valid & ~out_ready, except when killed by flush_mask[STAGES-1].
//  - out_data is don't-care when out_valid=0.
//  - Output handshake = out_valid & out_ready & ~stall. stall overrides out_ready, so no transfer occurs.
//  - occupancy = popcount of next vld_q, registered with it; never exceeds STAGES.
//  - STAGES=1: single register slot; in_ready = ~stall & (out_ready | ~out_valid).
//  - rst mid-operation: all in-flight entries dropped, nothing emitted the following cycle.
// CONFIGURATION
//  - Macro PIPE_STAGE_CHAIN_PERF_EN.
//  - Defined: three CNT_W saturating counters (stick at all-ones, no wrap).
//    * perf_retired: +1 per output handshake.
//    * perf_stalled: +1 per cycle stall=1.
//    * perf_flushed: +popcount(flush_mask & next-valid-before-flush).
//    * perf_clr=1 zeroes all three; it has priority over increment, one cycle.
//  - Undefined: counter logic absent; perf_* ports remain and are tied to 0; perf_clr ignored.
// TESTING
//  - Reset, STAGES=4: rst=1 two cycles ->
//    out_valid=0, occupancy=0, perf_*=0, in_ready=1 after release.
//  - Streaming: in_data=1..8 back-to-back, out_ready=1 ->
//    out_data 1..8 on consecutive cycles starting 4 cycles after first accept; occupancy peaks at 4.
//  - Backpressure: fill 4 entries, out_ready=0 ->
//    in_ready=0, out_data held at first item; out_ready=1 resumes in order, no loss or duplication.
//  - Stall: stall=1 for 3 cycles mid-stream ->
//    no stage moves, in_ready=0, no output handshake; perf_stalled=3 (PERF_EN).
//  - Flush: stages hold A,B,C,D (D oldest), flush_mask=4'b0011 with adv=1 and in_valid (E) ->
//    next cycle stage3=C valid, stage2=B valid, stages 1..0 invalid.
//    E consumed; occupancy=2; perf_flushed=2 (A and E).
//  - Saturation (CNT_W=4, PERF_EN): 20 handshakes -> perf_retired=15;
//    perf_clr pulse -> 0; without macro all perf_* read 0.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: N-stage valid/ready pipeline register chain with a
// global stall, per-stage flush and optional performance counters.
// Stage 0 is the youngest entry; stage STAGES-1 drives the output.
// Optional feature macro: PIPE_STAGE_CHAIN_PERF_EN enables saturating
// retired/stalled/flushed counters. Without it the perf_* ports read 0.
module pipe_stage_chain #(
  parameter int STAGES = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        stall,
  input  logic [STAGES-1:0]           flush_mask,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  input  logic                        perf_clr,
  output logic [CNT_W-1:0]            perf_retired,
  output logic [CNT_W-1:0]            perf_stalled,
  output logic [CNT_W-1:0]            perf_flushed
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0][DATA_W-1:0] data_q;
  logic [STAGES-1:0]             src_vld;
  logic [STAGES-1:0][DATA_W-1:0] src_data;
  logic [STAGES-1:0]             vld_pre;   // valid after shift/hold, before flush
  logic [STAGES-1:0]             vld_next;  // valid after flush
  logic [OCC_W-1:0]              occ_next;
  logic                          adv;

  // The whole chain moves as one unit: it advances whenever it is not
  // stalled and the output slot is either empty or being drained.
  assign adv       = ~stall & (out_ready | ~vld_q[STAGES-1]);
  assign in_ready  = rst ? ~stall : adv;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

  // Each stage's shift source: stage 0 from the input, others from their
  // younger neighbour. Invalid slots still move (no bubble collapse).
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
    if (gi == 0) begin : g_head
      assign src_vld[gi]  = in_valid;
      assign src_data[gi] = in_data;
    end else begin : g_body
      assign src_vld[gi]  = vld_q[gi-1];
      assign src_data[gi] = data_q[gi-1];
    end
    assign vld_pre[gi]  = adv ? src_vld[gi] : vld_q[gi];
    assign vld_next[gi] = vld_pre[gi] & ~flush_mask[gi];
  end

  // Occupancy is the popcount of the post-flush valid vector.
  always_comb begin
    occ_next = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_next = occ_next + OCC_W'(vld_next[i]);
    end
  end

  // Stage registers; flush only clears valids, payload simply follows adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      data_q    <= '0;
      occupancy <= '0;
    end else begin
      vld_q     <= vld_next;
      occupancy <= occ_next;
      if (adv) begin
        data_q <= src_data;
      end
    end
  end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic             out_hs;
  logic [OCC_W-1:0] flush_cnt;
  logic [CNT_W-1:0] retired_q, stalled_q, flushed_q;

  // Stall overrides out_ready, so a stalled cycle never retires an entry.
  assign out_hs = vld_q[STAGES-1] & out_ready & ~stall;

  // Count only entries that would have been valid had they not been killed.
  always_comb begin
    flush_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      flush_cnt = flush_cnt + OCC_W'(vld_pre[i] & flush_mask[i]);
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [OCC_W-1:0] b);
    logic [CNT_W+OCC_W-1:0] s;
    s = (CNT_W+OCC_W)'(a) + (CNT_W+OCC_W)'(b);
    if (s > (CNT_W+OCC_W)'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Saturating counters; clear wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      retired_q <= '0;
      stalled_q <= '0;
      flushed_q <= '0;
    end else begin
      retired_q <= sat_add(retired_q, OCC_W'(out_hs));
      stalled_q <= sat_add(stalled_q, OCC_W'(stall));
      flushed_q <= sat_add(flushed_q, flush_cnt);
    end
  end

  assign perf_retired = retired_q;
  assign perf_stalled = stalled_q;
  assign perf_flushed = flushed_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_retired    = '0;
  assign perf_stalled    = '0;
  assign perf_flushed    = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=4, DATA_W=32, CNT_W=4).
// Perf expectations follow PIPE_STAGE_CHAIN_PERF_EN: counts when defined,
// zero otherwise.
module tb_pipe_stage_chain;

  localparam int STAGES = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              stall;
  logic [STAGES-1:0] flush_mask;
  logic [2:0]        occupancy;
  logic              perf_clr;
  logic [CNT_W-1:0]  perf_retired;
  logic [CNT_W-1:0]  perf_stalled;
  logic [CNT_W-1:0]  perf_flushed;

  int checks = 0;
  int errors = 0;

  pipe_stage_chain #(.STAGES(STAGES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall(stall), .flush_mask(flush_mask), .occupancy(occupancy),
    .perf_clr(perf_clr), .perf_retired(perf_retired),
    .perf_stalled(perf_stalled), .perf_flushed(perf_flushed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lo, hi;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall = 1'b0; flush_mask = '0; perf_clr = 1'b0;

    // Reset for two cycles
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occ", {29'd0, occupancy}, 32'd0);
    chk("rst_retired", {28'd0, perf_retired}, 32'd0);
    chk("rst_stalled", {28'd0, perf_stalled}, 32'd0);
    chk("rst_flushed", {28'd0, perf_flushed}, 32'd0);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming 1..8 back-to-back, output always ready
    out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      in_valid = (c <= 8);
      in_data  = c;
      step();
      $display("stream cycle %0d: out_valid=%0d out_data=%0d occ=%0d", c, out_valid, out_data, occupancy);
      chk("stream_valid", {31'd0, out_valid}, (c >= 4 && c <= 11) ? 32'd1 : 32'd0);
      if (c >= 4 && c <= 11) chk("stream_data", out_data, c - 3);
      lo = (c - 3 < 1) ? 1 : c - 3;
      hi = (c < 8) ? c : 8;
      chk("stream_occ", {29'd0, occupancy}, (hi >= lo) ? hi - lo + 1 : 0);
    end

    // Backpressure: fill 11..14 with output blocked
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 11 + k;
      step();
    end
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_data", out_data, 32'd11);
    chk("bp_occ", {29'd0, occupancy}, 32'd4);
    in_data = 15;
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    step();
    $display("backpressure hold: out_data=%0d occ=%0d", out_data, occupancy);
    chk("bp_hold_data", out_data, 32'd11);
    chk("bp_hold_occ", {29'd0, occupancy}, 32'd4);
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    for (int k = 12; k <= 15; k++) begin
      $display("drain: out_valid=%0d out_data=%0d expect %0d", out_valid, out_data, k);
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_drain_data", out_data, k);
      step();
    end
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Stall with a full pipe
    perf_clr = 1'b1;
    for (int k = 21; k <= 24; k++) begin
      in_valid = 1'b1;
      in_data  = k;
      step();
      perf_clr = 1'b0;
    end
    chk("st_pre_data", out_data, 32'd21);
    stall   = 1'b1;
    in_data = 25;
    #1;
    chk("st_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      $display("stall cycle %0d: out_data=%0d occ=%0d", k, out_data, occupancy);
      chk("st_valid", {31'd0, out_valid}, 32'd1);
      chk("st_data", out_data, 32'd21);
      chk("st_occ", {29'd0, occupancy}, 32'd4);
    end
    chk("st_stalled", {28'd0, perf_stalled}, PERF ? 32'd3 : 32'd0);
    chk("st_retired", {28'd0, perf_retired}, 32'd0);
    stall = 1'b0;
    step();
    chk("st_release_data", out_data, 32'd22);
    chk("st_release_retired", {28'd0, perf_retired}, PERF ? 32'd1 : 32'd0);
    chk("st_release_stalled", {28'd0, perf_stalled}, PERF ? 32'd3 : 32'd0);

    // Flush everything, then load D,C,B,A (D oldest)
    in_valid = 1'b0; flush_mask = 4'hF; perf_clr = 1'b1;
    step();
    flush_mask = '0; perf_clr = 1'b0;
    chk("fl_all_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_all_occ", {29'd0, occupancy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hD - k;
      step();
    end
    chk("fl_pre_data", out_data, 32'hD);
    in_data = 32'hE; flush_mask = 4'b0011;
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; flush_mask = '0;
    $display("flush: out_data=%0h occ=%0d flushed=%0d", out_data, occupancy, perf_flushed);
    chk("fl_valid3", {31'd0, out_valid}, 32'd1);
    chk("fl_data3", out_data, 32'hC);
    chk("fl_occ", {29'd0, occupancy}, 32'd2);
    chk("fl_flushed", {28'd0, perf_flushed}, PERF ? 32'd2 : 32'd0);
    step();
    chk("fl_data2", out_data, 32'hB);
    chk("fl_valid2", {31'd0, out_valid}, 32'd1);
    step();
    chk("fl_killed_a", {31'd0, out_valid}, 32'd0);
    step();
    chk("fl_killed_e", {31'd0, out_valid}, 32'd0);

    // Saturation: 20 handshakes into a 4-bit counter
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    for (int k = 0; k < 24; k++) begin
      in_valid = (k < 20);
      in_data  = 100 + k;
      step();
    end
    $display("saturation: retired=%0d", perf_retired);
    chk("sat_retired", {28'd0, perf_retired}, PERF ? 32'd15 : 32'd0);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("sat_clr", {28'd0, perf_retired}, 32'd0);

    // Reset mid-operation drops in-flight entries
    in_valid = 1'b1;
    in_data  = 200;
    step();
    in_data = 201;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_occ", {29'd0, occupancy}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    step();
    step();
    $display("after mid reset: out_valid=%0d occ=%0d", out_valid, occupancy);
    chk("mid_rst_after_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_after_occ", {29'd0, occupancy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
